// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Definitions shared by the systolic array front-end blocks.
//   - feed_state_e : 2-bit state encoding of the activation feeder FSM
//   - clog2        : constant function used to size counters and length ports
//   - SYS_PE_ROW / SYS_INPUT_DATA_WIDTH : default array geometry, shared by the
//     feeder and the array itself so both agree on lane count and lane width
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int SYS_PE_ROW           = 16;
  localparam int SYS_INPUT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_STREAM = 2'd1,
    FEED_DRAIN  = 2'd2,
    FEED_SAVE   = 2'd3
  } feed_state_e;

  // Ceiling log2. Returns the number of bits needed to index 'value'
  // distinct items; clog2(MAX_LEN+1) therefore holds the count MAX_LEN itself.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/skew_delay.sv
// -----------------------------------------------------------------------------
// skew_delay
//   Fixed-length register line carrying a {valid, data} pair. One instance per
//   activation lane; lane r uses DELAY = 1 + r so that consecutive lanes are
//   offset by one cycle, producing the diagonal wavefront the array expects.
//   The line shifts every cycle and never stalls.
//
// Ports
//   clk_i    : clock, rising edge
//   rstn_i   : asynchronous active-low reset, clears every stage
//   valid_i  : valid bit entering stage 0
//   data_i   : data entering stage 0 (caller zeroes it when valid_i is low)
//   valid_o  : valid bit leaving the last stage
//   data_o   : data leaving the last stage
// -----------------------------------------------------------------------------
module skew_delay #(
  parameter int DELAY = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DELAY-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DELAY];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
      for (int i = 0; i < DELAY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < DELAY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DELAY-1];
  assign data_o  = data_q[DELAY-1];

endmodule

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//   Upstream stage of the systolic array. Accepts a tile of activation vectors
//   (one PE_ROW-wide vector per beat), skews lane r by r extra cycles, drives
//   the array's in_a_bus / per-row enable, flushes the skew pipe after the
//   last vector and then pulses save/done for one cycle.
//
// Handshake: a vector is transferred on a rising edge where s_valid and
//   s_ready are both high. s_ready is high only in STREAM and does not depend
//   on s_valid. The upstream may drop s_valid at any time (bubble); the feeder
//   never withdraws s_ready within STREAM except after the final beat.
//
// Ports
//   clk        : clock, rising edge
//   rstn       : asynchronous active-low reset
//   start      : tile start request, honoured in IDLE only, when len != 0
//   len        : vectors in the tile, sampled with start
//   s_valid    : input vector valid
//   s_ready    : feeder accepts a vector this cycle
//   s_data     : input vector, lane r at [r*IDW +: IDW]
//   in_a_bus   : skewed activations to the array, same packing
//   enable     : per-row valid to the array
//   save       : one-cycle tile-complete pulse to the array
//   busy       : high from the cycle after an accepted start through SAVE
//   done       : one-cycle pulse, coincident with save
//   dbg_state  : current FSM state, for observation only
// -----------------------------------------------------------------------------
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int PE_ROW           = SYS_PE_ROW,
  parameter int INPUT_DATA_WIDTH = SYS_INPUT_DATA_WIDTH,
  parameter int MAX_LEN          = 256,
  parameter int LEN_W            = clog2(MAX_LEN + 1)
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic [LEN_W-1:0]                   len,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [INPUT_DATA_WIDTH*PE_ROW-1:0] s_data,
  output logic [INPUT_DATA_WIDTH*PE_ROW-1:0] in_a_bus,
  output logic [PE_ROW-1:0]                  enable,
  output logic                               save,
  output logic                               busy,
  output logic                               done,
  output logic [1:0]                         dbg_state
);

  localparam int IDW     = INPUT_DATA_WIDTH;
  localparam int DRAIN_W = clog2(PE_ROW + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PE_ROW - 1);

  feed_state_e        state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               handshake;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FEED_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    unique case (state_q)
      FEED_IDLE: begin
        // A zero-length tile would never reach its last beat; drop it here.
        if (start && (len != '0)) begin
          len_d   = len;
          beat_d  = '0;
          state_d = FEED_STREAM;
        end
      end
      FEED_STREAM: begin
        if (s_valid) begin
          beat_d = beat_q + LEN_W'(1);
          // Leave on the same edge that accepts the final vector so s_ready
          // is already low in the following cycle.
          if (beat_d == len_q) begin
            drain_d = '0;
            state_d = FEED_DRAIN;
          end
        end
      end
      FEED_DRAIN: begin
        // PE_ROW cycles lets the deepest lane (1 + (PE_ROW-1) stages) empty.
        if (drain_q == DRAIN_LAST) begin
          state_d = FEED_SAVE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      FEED_SAVE: begin
        state_d = FEED_IDLE;
      end
      default: begin
        state_d = FEED_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from the registered state
  // ---------------------------------------------------------------------------
  assign s_ready   = (state_q == FEED_STREAM);
  assign handshake = s_valid && s_ready;
  assign save      = (state_q == FEED_SAVE);
  assign done      = save;
  assign busy      = (state_q != FEED_IDLE);
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Skew pipe: lane r delayed by 1 + r cycles. Non-handshake cycles inject a
  // zero bubble so data is always 0 whenever the matching enable is 0.
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < PE_ROW; r++) begin : g_lane
    logic [IDW-1:0] lane_in;

    assign lane_in = handshake ? s_data[r*IDW +: IDW] : '0;

    skew_delay #(
      .DELAY (1 + r),
      .WIDTH (IDW)
    ) u_skew (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .valid_i (handshake),
      .data_i  (lane_in),
      .valid_o (enable[r]),
      .data_o  (in_a_bus[r*IDW +: IDW])
    );
  end

endmodule
